// File: rtl/n101_sram_arb_if.sv
// Command/response channel between one bus master and the SRAM arbiter.
// A master drives the command and response-ready signals. The arbiter drives the grant and the response.
interface n101_sram_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MW = 4
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_read;
    logic [DW-1:0] cmd_wdata;
    logic [MW-1:0] cmd_wmask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    modport master (
        output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/n101_sram_arb.sv
// Round-robin arbiter/sequencer for one single-port SRAM with one-cycle read latency.
// It accepts at most one access per cycle and keeps a one-entry hold register for response backpressure.
module n101_sram_arb #(
    parameter int DP  = 512,
    parameter int AW  = 32,
    parameter int RAW = 9,
    parameter int DW  = 32,
    parameter int MW  = 4
) (
    input  logic           clk,
    input  logic           rst,
    n101_sram_arb_if.slave p0,
    n101_sram_arb_if.slave p1,
    output logic           ram_cs,
    output logic           ram_we,
    output logic [MW-1:0]  ram_wem,
    output logic [RAW-1:0] ram_addr,
    output logic [DW-1:0]  ram_din,
    input  logic [DW-1:0]  ram_dout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RSP  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Bits [1:0] of a byte address never change which side of this limit the address falls on.
    localparam logic [AW-1:0] ADDR_LIMIT = AW'(DP) << 2;

    logic [1:0]    state_r;
    logic          own_r;
    logic          rd_r;
    logic          err_r;
    logic          rr_r;
    logic [DW-1:0] hold_r;

    logic          owner_ready;
    logic          can_issue;
    logic          gnt0;
    logic          gnt1;
    logic          gnt;
    logic          oob;
    logic          rsp_active;
    logic [AW-1:0] sel_addr;
    logic          sel_read;
    logic [DW-1:0] sel_wdata;
    logic [MW-1:0] sel_wmask;
    logic [DW-1:0] rsp_data;

    always_comb begin
        owner_ready = own_r ? p1.rsp_ready : p0.rsp_ready;
        // NOTE: the async reset only clears registers. The combinational grant path needs rst as well,
        // so no grant, no response and no RAM access appear while rst is high.
        can_issue   = !rst && (state_r == ST_IDLE || owner_ready);

        gnt0 = can_issue && p0.cmd_valid && (!p1.cmd_valid || !rr_r);
        gnt1 = can_issue && p1.cmd_valid && (!p0.cmd_valid ||  rr_r);
        gnt  = gnt0 || gnt1;

        sel_addr  = gnt1 ? p1.cmd_addr  : p0.cmd_addr;
        sel_read  = gnt1 ? p1.cmd_read  : p0.cmd_read;
        sel_wdata = gnt1 ? p1.cmd_wdata : p0.cmd_wdata;
        sel_wmask = gnt1 ? p1.cmd_wmask : p0.cmd_wmask;
        oob       = sel_addr >= ADDR_LIMIT;

        ram_cs   = gnt && !oob;
        ram_we   = ram_cs && !sel_read;
        ram_wem  = ram_we ? sel_wmask : '0;
        ram_addr = sel_addr[RAW+1:2];
        ram_din  = sel_wdata;

        rsp_active = !rst && (state_r != ST_IDLE);
        if (state_r == ST_HOLD) begin
            rsp_data = hold_r;
        end else if (rd_r && !err_r) begin
            rsp_data = ram_dout;
        end else begin
            rsp_data = '0;
        end
    end

    assign p0.cmd_ready = gnt0;
    assign p1.cmd_ready = gnt1;

    assign p0.rsp_valid = rsp_active && !own_r;
    assign p1.rsp_valid = rsp_active &&  own_r;
    assign p0.rsp_rdata = own_r ? '0 : rsp_data;
    assign p1.rsp_rdata = own_r ? rsp_data : '0;
    assign p0.rsp_err   = rsp_active && !own_r && err_r;
    assign p1.rsp_err   = rsp_active &&  own_r && err_r;

    // NOTE: sequential state uses non-blocking assignments only. This keeps every register sampling
    // its inputs from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            own_r   <= 1'b0;
            rd_r    <= 1'b0;
            err_r   <= 1'b0;
            rr_r    <= 1'b0;
            hold_r  <= '0;
        end else begin
            if (gnt) begin
                state_r <= ST_RSP;
                own_r   <= gnt1;
                rd_r    <= sel_read;
                err_r   <= oob;
            end else if (state_r == ST_RSP && !owner_ready) begin
                // Capture now, because ram_dout is only guaranteed for the cycle after the read.
                state_r <= ST_HOLD;
                hold_r  <= rsp_data;
            end else if (state_r != ST_IDLE && owner_ready) begin
                state_r <= ST_IDLE;
            end

            if (gnt && p0.cmd_valid && p1.cmd_valid) begin
                rr_r <= gnt0;
            end
        end
    end

endmodule

// File: tb/tb_n101_sram_arb.sv
// Self-checking bench for n101_sram_arb. A behavioural SRAM sits behind the DUT.
// A shadow memory and response queue predict every response.
module tb_n101_sram_arb;

    localparam int DP = 512;

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic        ram_cs;
    logic        ram_we;
    logic [3:0]  ram_wem;
    logic [8:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    n101_sram_arb_if #(.AW(32), .DW(32), .MW(4)) p0_if ();
    n101_sram_arb_if #(.AW(32), .DW(32), .MW(4)) p1_if ();

    n101_sram_arb #(.DP(DP), .AW(32), .RAW(9), .DW(32), .MW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .p0       (p0_if),
        .p1       (p1_if),
        .ram_cs   (ram_cs),
        .ram_we   (ram_we),
        .ram_wem  (ram_wem),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    logic [31:0] ram_mem [DP];

    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_wem[b]) ram_mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
                end
            end else begin
                ram_dout <= ram_mem[ram_addr];
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total;
    int          bad;
    rsp_t        exp_q[$];
    logic [31:0] model_mem [DP];

    logic        s_v0, s_v1, s_g0, s_g1, s_e0, s_e1, s_cs, s_we;
    logic [31:0] s_d0, s_d1;
    logic [3:0]  s_wem;
    logic [8:0]  s_addr;

    task automatic drive(input int p, input logic v, input logic rd, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] wm);
        if (p == 0) begin
            p0_if.cmd_valid = v; p0_if.cmd_read = rd; p0_if.cmd_addr = a;
            p0_if.cmd_wdata = wd; p0_if.cmd_wmask = wm;
        end else begin
            p1_if.cmd_valid = v; p1_if.cmd_read = rd; p1_if.cmd_addr = a;
            p1_if.cmd_wdata = wd; p1_if.cmd_wmask = wm;
        end
    endtask

    task automatic sb_push(input logic port, input logic [31:0] a, input logic rd,
                           input logic [31:0] wd, input logic [3:0] wm);
        rsp_t        e;
        logic [8:0]  idx;
        logic [31:0] word;
        idx    = a[10:2];
        e.port = port;
        if (a >= 32'(DP * 4)) begin
            e.rdata = '0; e.err = 1'b1;
        end else if (rd) begin
            e.rdata = model_mem[idx]; e.err = 1'b0;
        end else begin
            word = model_mem[idx];
            for (int b = 0; b < 4; b++) begin
                if (wm[b]) word[b*8 +: 8] = wd[b*8 +: 8];
            end
            model_mem[idx] = word;
            e.rdata = '0; e.err = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    task automatic sb_take(input logic port, input logic [31:0] d, input logic er);
        rsp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: port%0d got rdata=%h err=%b, want no response", port, d, er);
        end else begin
            e = exp_q.pop_front();
            if (e.port !== port || e.rdata !== d || e.err !== er) begin
                bad++;
                $display("FAIL sb_rsp: got port%0d rdata=%h err=%b, want port%0d rdata=%h err=%b",
                         port, d, er, e.port, e.rdata, e.err);
            end
        end
    endtask

    // One cycle: sample at the falling edge, feed the scoreboard, then return 1 after the next rising edge.
    task automatic step();
        @(negedge clk);
        s_v0 = p0_if.rsp_valid; s_d0 = p0_if.rsp_rdata; s_e0 = p0_if.rsp_err;
        s_v1 = p1_if.rsp_valid; s_d1 = p1_if.rsp_rdata; s_e1 = p1_if.rsp_err;
        s_g0 = p0_if.cmd_ready; s_g1 = p1_if.cmd_ready;
        s_cs = ram_cs; s_we = ram_we; s_wem = ram_wem; s_addr = ram_addr;
        if (s_v0 && p0_if.rsp_ready) sb_take(1'b0, s_d0, s_e0);
        if (s_v1 && p1_if.rsp_ready) sb_take(1'b1, s_d1, s_e1);
        if (s_g0) sb_push(1'b0, p0_if.cmd_addr, p0_if.cmd_read, p0_if.cmd_wdata, p0_if.cmd_wmask);
        if (s_g1) sb_push(1'b1, p1_if.cmd_addr, p1_if.cmd_read, p1_if.cmd_wdata, p1_if.cmd_wmask);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive(0, 1'b1, 1'b1, 32'h10, '0, '0);
        drive(1, 1'b1, 1'b1, 32'h10, '0, '0);
        p0_if.rsp_ready = 1'b1; p1_if.rsp_ready = 1'b1;
        rst = 1'b1;
        #1;
        total++;
        if (p0_if.cmd_ready !== 1'b0 || p1_if.cmd_ready !== 1'b0 || ram_cs !== 1'b0) begin
            bad++;
            $display("FAIL reset_grant: got rdy0=%b rdy1=%b cs=%b, want 0 0 0",
                     p0_if.cmd_ready, p1_if.cmd_ready, ram_cs);
        end
        step();
        total++;
        if (s_v0 !== 1'b0 || s_v1 !== 1'b0 || s_cs !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got v0=%b v1=%b cs=%b, want 0 0 0", s_v0, s_v1, s_cs);
        end
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        rst = 1'b0;
        step();
        total++;
        if (s_v0 !== 1'b0 || s_v1 !== 1'b0 || s_g0 !== 1'b0 || s_g1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got v0=%b v1=%b g0=%b g1=%b, want all 0", s_v0, s_v1, s_g0, s_g1);
        end
    endtask

    task automatic test_write_read();
        drive(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF);
        step();
        total++;
        if (s_g0 !== 1'b1 || s_cs !== 1'b1 || s_we !== 1'b1 || s_wem !== 4'hF || s_addr !== 9'd4) begin
            bad++;
            $display("FAIL wr_issue: got g0=%b cs=%b we=%b wem=%h addr=%h, want 1 1 1 f 004",
                     s_g0, s_cs, s_we, s_wem, s_addr);
        end
        drive(0, 1'b1, 1'b1, 32'h10, '0, 4'hF);
        step();
        total++;
        if (s_v0 !== 1'b1 || s_d0 !== 32'h0 || s_e0 !== 1'b0) begin
            bad++;
            $display("FAIL wr_rsp: got v=%b rdata=%h err=%b, want 1 00000000 0", s_v0, s_d0, s_e0);
        end
        total++;
        if (s_g0 !== 1'b1 || s_cs !== 1'b1 || s_we !== 1'b0 || s_wem !== 4'h0) begin
            bad++;
            $display("FAIL rd_issue: got g0=%b cs=%b we=%b wem=%h, want 1 1 0 0", s_g0, s_cs, s_we, s_wem);
        end
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        step();
        total++;
        if (s_v0 !== 1'b1 || s_d0 !== 32'hDEADBEEF || s_e0 !== 1'b0) begin
            bad++;
            $display("FAIL rd_rsp: got v=%b rdata=%h err=%b, want 1 deadbeef 0", s_v0, s_d0, s_e0);
        end
        step();
        total++;
        if (s_v0 !== 1'b0) begin
            bad++;
            $display("FAIL rsp_done: got v0=%b, want 0", s_v0);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        p0_if.rsp_ready = 1'b1; p1_if.rsp_ready = 1'b1;
        drive(0, 1'b1, 1'b1, 32'h10, '0, '0);
        drive(1, 1'b1, 1'b1, 32'h10, '0, '0);
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (s_g0 !== (i % 2 == 0) || s_g1 !== (i % 2 == 1)) begin
                bad++;
                $display("FAIL rr_grant[%0d]: got g0=%b g1=%b, want g0=%b g1=%b",
                         i, s_g0, s_g1, i % 2 == 0, i % 2 == 1);
            end
            if (i > 0) begin
                total++;
                if (s_v0 !== (i % 2 == 1) || s_v1 !== (i % 2 == 0)) begin
                    bad++;
                    $display("FAIL rr_rsp[%0d]: got v0=%b v1=%b, want v0=%b v1=%b",
                             i, s_v0, s_v1, i % 2 == 1, i % 2 == 0);
                end
            end
        end
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        step();
        total++;
        if (s_v0 !== 1'b0 || s_v1 !== 1'b1 || s_d1 !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL rr_last: got v0=%b v1=%b rdata=%h, want 0 1 deadbeef", s_v0, s_v1, s_d1);
        end
    endtask

    task automatic test_hold();
        p0_if.rsp_ready = 1'b1; p1_if.rsp_ready = 1'b1;
        drive(1, 1'b1, 1'b0, 32'h20, 32'h12345678, 4'hF);
        step();
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        step();
        drive(1, 1'b1, 1'b1, 32'h20, '0, '0);
        step();
        total++;
        if (s_g1 !== 1'b1) begin
            bad++;
            $display("FAIL hold_rd_grant: got g1=%b, want 1", s_g1);
        end
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        p1_if.rsp_ready = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (s_v1 !== 1'b1 || s_d1 !== 32'h12345678 || s_g0 !== 1'b0 || s_cs !== 1'b0) begin
                bad++;
                $display("FAIL hold_wait[%0d]: got v1=%b rdata=%h g0=%b cs=%b, want 1 12345678 0 0",
                         k, s_v1, s_d1, s_g0, s_cs);
            end
        end
        p1_if.rsp_ready = 1'b1;
        step();
        total++;
        if (s_v1 !== 1'b1 || s_d1 !== 32'h12345678 || s_g0 !== 1'b1 || s_cs !== 1'b1) begin
            bad++;
            $display("FAIL hold_release: got v1=%b rdata=%h g0=%b cs=%b, want 1 12345678 1 1",
                     s_v1, s_d1, s_g0, s_cs);
        end
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        step();
        total++;
        if (s_v0 !== 1'b1 || s_v1 !== 1'b0 || s_d0 !== 32'h0) begin
            bad++;
            $display("FAIL hold_p0_rsp: got v0=%b v1=%b rdata=%h, want 1 0 00000000", s_v0, s_v1, s_d0);
        end
    endtask

    task automatic test_out_of_range();
        p0_if.rsp_ready = 1'b1;
        drive(0, 1'b1, 1'b1, 32'(DP * 4), '0, '0);
        step();
        total++;
        if (s_g0 !== 1'b1 || s_cs !== 1'b0) begin
            bad++;
            $display("FAIL oob_issue: got g0=%b cs=%b, want 1 0", s_g0, s_cs);
        end
        drive(0, 1'b1, 1'b0, 32'h1000_0000, 32'hFFFFFFFF, 4'hF);
        step();
        total++;
        if (s_v0 !== 1'b1 || s_e0 !== 1'b1 || s_d0 !== 32'h0) begin
            bad++;
            $display("FAIL oob_rsp: got v=%b err=%b rdata=%h, want 1 1 00000000", s_v0, s_e0, s_d0);
        end
        total++;
        if (s_g0 !== 1'b1 || s_cs !== 1'b0) begin
            bad++;
            $display("FAIL oob_wr_issue: got g0=%b cs=%b, want 1 0", s_g0, s_cs);
        end
        drive(0, 1'b1, 1'b0, 32'(DP * 4 - 4), 32'hA5A5A5A5, 4'hF);
        step();
        total++;
        if (s_cs !== 1'b1 || s_addr !== 9'h1FF || s_e0 !== 1'b1) begin
            bad++;
            $display("FAIL last_word_wr: got cs=%b addr=%h prev_err=%b, want 1 1ff 1", s_cs, s_addr, s_e0);
        end
        drive(0, 1'b1, 1'b1, 32'(DP * 4 - 4), '0, '0);
        step();
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        step();
        total++;
        if (s_v0 !== 1'b1 || s_e0 !== 1'b0 || s_d0 !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL last_word_rd: got v=%b err=%b rdata=%h, want 1 0 a5a5a5a5", s_v0, s_e0, s_d0);
        end
    endtask

    task automatic test_partial_write();
        p0_if.rsp_ready = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h30, 32'hFFFFFFFF, 4'hF);
        step();
        drive(0, 1'b1, 1'b0, 32'h30, 32'h0000AB00, 4'h2);
        step();
        total++;
        if (s_we !== 1'b1 || s_wem !== 4'h2 || s_addr !== 9'h00C) begin
            bad++;
            $display("FAIL part_issue: got we=%b wem=%h addr=%h, want 1 2 00c", s_we, s_wem, s_addr);
        end
        drive(0, 1'b1, 1'b1, 32'h33, '0, '0);
        step();
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        step();
        total++;
        if (s_v0 !== 1'b1 || s_d0 !== 32'hFFFFABFF) begin
            bad++;
            $display("FAIL part_rd: got v=%b rdata=%h, want 1 ffffabff", s_v0, s_d0);
        end
    endtask

    task automatic test_reset_in_hold();
        p0_if.rsp_ready = 1'b0;
        drive(0, 1'b1, 1'b1, 32'h10, '0, '0);
        drive(1, 1'b1, 1'b1, 32'h20, '0, '0);
        step();
        total++;
        if (s_g0 !== 1'b1 || s_g1 !== 1'b0) begin
            bad++;
            $display("FAIL rih_pre_grant: got g0=%b g1=%b, want 1 0", s_g0, s_g1);
        end
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        step();
        step();
        total++;
        if (s_v0 !== 1'b1 || s_d0 !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL rih_hold: got v0=%b rdata=%h, want 1 deadbeef", s_v0, s_d0);
        end
        drive(0, 1'b1, 1'b1, 32'h10, '0, '0);
        drive(1, 1'b1, 1'b1, 32'h20, '0, '0);
        rst = 1'b1;
        #1;
        total++;
        if (p0_if.rsp_valid !== 1'b0 || p0_if.cmd_ready !== 1'b0 || p1_if.cmd_ready !== 1'b0 || ram_cs !== 1'b0) begin
            bad++;
            $display("FAIL rih_immediate: got v0=%b rdy0=%b rdy1=%b cs=%b, want 0 0 0 0",
                     p0_if.rsp_valid, p0_if.cmd_ready, p1_if.cmd_ready, ram_cs);
        end
        exp_q.delete();
        step();
        rst = 1'b0;
        p0_if.rsp_ready = 1'b1; p1_if.rsp_ready = 1'b1;
        step();
        total++;
        if (s_g0 !== 1'b1 || s_g1 !== 1'b0 || s_v0 !== 1'b0 || s_v1 !== 1'b0) begin
            bad++;
            $display("FAIL rih_after: got g0=%b g1=%b v0=%b v1=%b, want 1 0 0 0", s_g0, s_g1, s_v0, s_v1);
        end
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        step();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        p0_if.rsp_ready = 1'b0;
        p1_if.rsp_ready = 1'b0;
        @(posedge clk);
        #1;

        test_reset();
        test_write_read();
        test_round_robin();
        test_hold();
        test_out_of_range();
        test_partial_write();
        test_reset_in_hold();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending responses, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
